// File: rtl/uart_rx_regwr_if.sv
// Receive-side bundle of the UART register loader.
// The master (the receiver) drives the received-byte status and the
// register-file write strobe. The slave (register file / observer) reads them.
`timescale 1ns/1ps

interface uart_rx_regwr_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;

    modport master (
        output rx_data, rx_valid, frame_err, busy,
        output we3, wa3, wd3
    );

    modport slave (
        input rx_data, rx_valid, frame_err, busy,
        input we3, wa3, wd3
    );
endinterface

// File: rtl/uart_rx_regwr.sv
// 8N1 UART receiver that assembles two-byte write commands for the register file.
// A header byte whose upper five bits match HDR carries the target address in its
// low three bits. The following good byte is the write data. Each complete command
// yields a single-cycle we3/wa3/wd3 strobe.
`timescale 1ns/1ps

module uart_rx_regwr #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [4:0] HDR          = 5'b10101
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iRXD,
    uart_rx_regwr_if.master bus
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rxState_t;

    typedef enum logic {
        P_HDR,
        P_DATA
    } pktState_t;

    logic            sync1_q;
    logic            rxs_q;
    rxState_t        rxState_q;
    logic [CW-1:0]   bitCnt_q;
    logic [2:0]      bitIdx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rxData_q;
    logic            rxValid_q;
    logic            frameErr_q;

    pktState_t       pktState_q;
    logic [2:0]      addr_q;
    logic            we3_q;
    logic [2:0]      wa3_q;
    logic [7:0]      wd3_q;

    // Two-flop synchronizer. The line idles high, so both flops reset to 1.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= iRXD;
            rxs_q   <= sync1_q;
        end
    end

    // Receive FSM. It re-checks the start bit at its midpoint, then samples each
    // data bit and the stop bit one full bit time apart. A low stop bit parks the
    // FSM in BREAK until the line returns high, so a held-low line cannot start a
    // new frame.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rxState_q  <= S_IDLE;
            bitCnt_q   <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            case (rxState_q)
                S_IDLE: begin
                    bitCnt_q <= '0;
                    if (!rxs_q) begin
                        rxState_q <= S_START;
                    end
                end
                S_START: begin
                    if (bitCnt_q == HALF) begin
                        bitCnt_q <= '0;
                        bitIdx_q <= '0;
                        rxState_q <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bitCnt_q == FULL) begin
                        bitCnt_q          <= '0;
                        shift_q[bitIdx_q] <= rxs_q;
                        if (bitIdx_q == 3'd7) begin
                            rxState_q <= S_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bitCnt_q == FULL) begin
                        bitCnt_q <= '0;
                        if (rxs_q) begin
                            rxData_q  <= shift_q;
                            rxValid_q <= 1'b1;
                            rxState_q <= S_IDLE;
                        end else begin
                            frameErr_q <= 1'b1;
                            rxState_q  <= S_BREAK;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        rxState_q <= S_IDLE;
                    end
                end
                default: rxState_q <= S_IDLE;
            endcase
        end
    end

    // Packet FSM. It steps only on received-byte events. A framing error
    // abandons any half-built command, so a corrupted link never writes.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pktState_q <= P_HDR;
            addr_q     <= '0;
            we3_q      <= 1'b0;
            wa3_q      <= '0;
            wd3_q      <= '0;
        end else begin
            we3_q <= 1'b0;
            if (frameErr_q) begin
                pktState_q <= P_HDR;
            end else if (rxValid_q) begin
                case (pktState_q)
                    P_HDR: begin
                        if (rxData_q[7:3] == HDR) begin
                            addr_q     <= rxData_q[2:0];
                            pktState_q <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        we3_q      <= 1'b1;
                        wa3_q      <= addr_q;
                        wd3_q      <= rxData_q;
                        pktState_q <= P_HDR;
                    end
                    default: pktState_q <= P_HDR;
                endcase
            end
        end
    end

    assign bus.rx_data   = rxData_q;
    assign bus.rx_valid  = rxValid_q;
    assign bus.frame_err = frameErr_q;
    assign bus.busy      = (rxState_q != S_IDLE);
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;

endmodule

// File: tb/tb_uart_rx_regwr.sv
// Bench for uart_rx_regwr at 16 clocks per bit.
// Each frame sent queues the byte it should produce, and also the register write
// it should produce. A negedge monitor pops those queues as the DUT reports bytes
// and writes.
`timescale 1ns/1ps

module tb_uart_rx_regwr;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       hasWrite;
        logic [2:0] wa;
        logic [7:0] wd;
    } vec_t;

    logic clock = 1'b0;
    logic rstN;
    logic rxd;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int lastValidCycle = -100;
    int errExpected = 0;

    logic [7:0]  expRx[$];
    logic [10:0] expWr[$];
    vec_t        vecs[8];

    uart_rx_regwr_if bus();

    uart_rx_regwr #(
        .CLKS_PER_BIT(CPB),
        .HDR(5'b10101)
    ) dut (
        .iCLK(clock),
        .iRST_N(rstN),
        .iRXD(rxd),
        .bus(bus)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_data"},   {24'b0, bus.rx_data},   32'd0);
        checkOutput({tag, "_rx_valid"},  {31'b0, bus.rx_valid},  32'd0);
        checkOutput({tag, "_frame_err"}, {31'b0, bus.frame_err}, 32'd0);
        checkOutput({tag, "_busy"},      {31'b0, bus.busy},      32'd0);
        checkOutput({tag, "_we3"},       {31'b0, bus.we3},       32'd0);
        checkOutput({tag, "_wa3"},       {29'b0, bus.wa3},       32'd0);
        checkOutput({tag, "_wd3"},       {24'b0, bus.wd3},       32'd0);
    endtask

    // Drives one 8N1 frame, LSB first. Call aligned to a falling clock edge.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge clock);
        end
        rxd = stopBit;
        repeat (CPB) @(negedge clock);
    endtask

    // Queues what a good frame should produce, then transmits it.
    task automatic applyStimulus(input logic [7:0] data, input logic hasWrite,
                                 input logic [2:0] wa, input logic [7:0] wd);
        expRx.push_back(data);
        if (hasWrite) expWr.push_back({wa, wd});
        sendFrame(data, 1'b1);
    endtask

    // Waits up to maxCycles for the receiver to go idle, then records the result.
    task automatic waitIdle(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles && bus.busy; i++) @(negedge clock);
        checkOutput(name, {31'b0, bus.busy}, 32'd0);
    endtask

    // Scoreboard monitor: every DUT pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (rstN) begin
            if (bus.rx_valid || bus.frame_err)
                checkOutput("valid_err_exclusive", {31'b0, bus.rx_valid & bus.frame_err}, 32'd0);
            if (bus.we3) begin
                checkOutput("we3_latency", cycle - lastValidCycle, 32'd1);
                if (expWr.size() == 0)
                    checkOutput("unexpected_we3", {31'b0, bus.we3}, 32'd0);
                else
                    checkOutput("write_addr_data", {21'b0, bus.wa3, bus.wd3},
                                {21'b0, expWr.pop_front()});
            end
            if (bus.rx_valid) begin
                lastValidCycle = cycle;
                if (expRx.size() == 0)
                    checkOutput("unexpected_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
                else
                    checkOutput("rx_data", {24'b0, bus.rx_data}, {24'b0, expRx.pop_front()});
            end
            if (bus.frame_err) begin
                if (errExpected == 0)
                    checkOutput("unexpected_frame_err", {31'b0, bus.frame_err}, 32'd0);
                else
                    errExpected--;
            end
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset checks, the command table, then the multi-cycle corner cases.
    initial begin
        vecs[0] = '{8'hA5, 1'b0, 3'd0, 8'h00};
        vecs[1] = '{8'hAB, 1'b0, 3'd0, 8'h00};
        vecs[2] = '{8'h7E, 1'b1, 3'd3, 8'h7E};
        vecs[3] = '{8'h12, 1'b0, 3'd0, 8'h00};
        vecs[4] = '{8'hA8, 1'b0, 3'd0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 3'd0, 8'hFF};
        vecs[6] = '{8'hAF, 1'b0, 3'd0, 8'h00};
        vecs[7] = '{8'h00, 1'b1, 3'd7, 8'h00};

        rstN = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        rstN = 1'b1;
        repeat (4) @(negedge clock);

        // Reset in the middle of a frame: the partial byte must vanish.
        rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        rxd = 1'b1;
        repeat (CPB) @(negedge clock);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        checkOutput("midframe_busy", {31'b0, bus.busy}, 32'd1);
        rstN = 1'b0;
        rxd  = 1'b1;
        @(negedge clock);
        checkAllZero("midreset");
        repeat (2) @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("post_reset_busy", {31'b0, bus.busy}, 32'd0);
        repeat (2 * CPB) @(negedge clock);
        applyStimulus(8'h3C, 1'b0, 3'd0, 8'h00);
        checkOutput("rx_data_hold_3c", {24'b0, bus.rx_data}, 32'h3C);

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].data, vecs[i].hasWrite, vecs[i].wa, vecs[i].wd);
        repeat (4) @(negedge clock);
        checkOutput("table_rx_drained", expRx.size(), 32'd0);
        checkOutput("table_wr_drained", expWr.size(), 32'd0);

        // Start glitch shorter than half a bit is rejected.
        repeat (CPB) @(negedge clock);
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        checkOutput("glitch_busy_high", {31'b0, bus.busy}, 32'd1);
        waitIdle("glitch_busy_low", 10);
        repeat (CPB) @(negedge clock);

        // Header, then a frame with a low stop bit and the line held low.
        applyStimulus(8'hAD, 1'b0, 3'd0, 8'h00);
        errExpected = 1;
        rxd = 1'b0;
        repeat (30 * CPB) @(negedge clock);
        checkOutput("break_busy", {31'b0, bus.busy}, 32'd1);
        checkOutput("break_frame_err_count", errExpected, 32'd0);
        checkOutput("break_rx_data_held", {24'b0, bus.rx_data}, 32'hAD);
        rxd = 1'b1;
        waitIdle("break_release_idle", 10);
        repeat (CPB) @(negedge clock);
        applyStimulus(8'hA9, 1'b0, 3'd0, 8'h00);
        applyStimulus(8'h11, 1'b1, 3'd1, 8'h11);

        repeat (40) @(negedge clock);
        checkOutput("final_rx_drained", expRx.size(), 32'd0);
        checkOutput("final_wr_drained", expWr.size(), 32'd0);
        checkOutput("final_err_drained", errExpected, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
